// File: rtl/fir_pkg.sv
// Shared widths, the accumulator width rule and the FSM encoding for the
// streaming FIR MAC stage.
package fir_pkg;

  localparam int FIR_DATA_W = 16;
  localparam int FIR_COEF_W = 16;
  localparam int FIR_TAPS   = 8;

  // Full-precision sum of TAPS products needs log2(TAPS) guard bits.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate datapath: one product per enabled cycle.
// `sum` is the combinational next accumulator value so the caller can
// capture the final result on the same edge the last product lands.
module fir_mac_unit #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 35
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] sample,
  input  logic [COEF_W-1:0] coef,
  output logic [ACC_W-1:0]  sum
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic        [ACC_W-1:0]  acc;

  assign prod = $signed(sample) * $signed(coef);
  assign sum  = acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/fir_stream_mac.sv
// Sequential FIR stage: pops one sample from the upstream buffer, runs TAPS
// signed MACs over the history and offers the sum on a valid/ready port.
module fir_stream_mac
  import fir_pkg::*;
#(
  parameter  int DATA_W = FIR_DATA_W,
  parameter  int COEF_W = FIR_COEF_W,
  parameter  int TAPS   = FIR_TAPS,
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS),
  localparam int K_W    = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              read_en,
  input  logic              coef_wen,
  input  logic [K_W-1:0]    coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: input pops on read_en & in_valid (read_en only in IDLE);
  // output transfers on out_valid & out_ready, out_data held until then.

  fir_state_t        state;
  logic [K_W-1:0]    k;
  logic [DATA_W-1:0] hist [TAPS];
  logic [COEF_W-1:0] coef [TAPS];
  logic [ACC_W-1:0]  mac_sum;
  logic              accept;

  assign read_en   = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign accept    = (state == IDLE) && in_valid;

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (state == MAC),
    .sample (hist[k]),
    .coef   (coef[k]),
    .sum    (mac_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // Address decode per tap: addresses beyond TAPS-1 match nothing.
          for (int i = 0; i < TAPS; i++) begin
            if (coef_wen && coef_addr == K_W'(i)) coef[i] <= coef_data;
          end
          if (in_valid) begin
            hist[0] <= in_data;
            for (int i = 1; i < TAPS; i++) hist[i] <= hist[i-1];
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (k == K_W'(TAPS - 1)) begin
            out_data  <= mac_sum;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_mac.sv
// Directed bench for fir_stream_mac with TAPS=4 (34-bit results).
module tb_fir_stream_mac;

  localparam int TAPS  = 4;
  localparam int ACC_W = 34;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [15:0]       in_data = '0;
  logic              read_en;
  logic              coef_wen = 1'b0;
  logic [1:0]        coef_addr = '0;
  logic [15:0]       coef_data = '0;
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;
  logic              out_ready = 1'b1;
  logic              busy;
  logic [1:0]        dbg_state;

  int total = 0;
  int passed = 0;

  fir_stream_mac #(.TAPS(TAPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .read_en   (read_en),
    .coef_wen  (coef_wen),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [15:0] d);
    coef_wen = 1'b1; coef_addr = a; coef_data = d;
    tick();
    coef_wen = 1'b0;
  endtask

  task automatic set_coefs(input logic [15:0] c0, c1, c2, c3);
    write_coef(2'd0, c0); write_coef(2'd1, c1);
    write_coef(2'd2, c2); write_coef(2'd3, c3);
  endtask

  // lat = rising edges after the accept edge until out_valid is seen
  // (TAPS edges means out_valid is up in cycle accept+TAPS+1).
  task automatic push_sample(input logic [15:0] s, input bit wr_acc, input bit wr_mac,
                             input logic [1:0] wa, input logic [15:0] wd,
                             output int lat, output logic [ACC_W-1:0] y);
    int n;
    lat = -1;
    y   = '0;
    n   = 0;
    while (!read_en && n < 50) begin tick(); n++; end
    if (!read_en) begin
      total++;
      $display("FAIL push_wait_read_en: read_en=%b required 1", read_en);
      return;
    end
    in_valid = 1'b1; in_data = s;
    if (wr_acc) begin coef_wen = 1'b1; coef_addr = wa; coef_data = wd; end
    tick();
    in_valid = 1'b0; coef_wen = 1'b0;
    if (wr_mac) begin coef_wen = 1'b1; coef_addr = wa; coef_data = wd; end
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    coef_wen = 1'b0;
    if (!out_valid) begin
      total++;
      $display("FAIL push_wait_out_valid: out_valid=%b required 1", out_valid);
      return;
    end
    lat = n;
    y   = out_data;
    if (out_ready) tick();
  endtask

  task automatic check_y(input string name, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0d required %0d", name, $signed(got), $signed(exp));
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      total += 5;
      if (read_en !== 1'b1) $display("FAIL reset_read_en cyc%0d: got %b required 1", c, read_en); else passed++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid cyc%0d: got %b required 0", c, out_valid); else passed++;
      if (out_data !== '0) $display("FAIL reset_out_data cyc%0d: got %0d required 0", c, out_data); else passed++;
      if (busy !== 1'b0) $display("FAIL reset_busy cyc%0d: got %b required 0", c, busy); else passed++;
      if (dbg_state !== 2'd0) $display("FAIL reset_state cyc%0d: got %0d required 0", c, dbg_state); else passed++;
    end
  endtask

  task automatic test_impulse();
    logic [ACC_W-1:0] exp_y [5];
    logic [15:0]      smp [5];
    int               lat;
    logic [ACC_W-1:0] y;
    exp_y = '{34'd1, 34'd2, 34'd3, 34'd4, 34'd0};
    smp   = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
    set_coefs(16'd1, 16'd2, 16'd3, 16'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_sample(smp[i], 1'b0, 1'b0, 2'd0, 16'd0, lat, y);
      check_y($sformatf("impulse_y%0d", i), y, exp_y[i]);
      total++;
      if (lat !== TAPS) $display("FAIL impulse_latency%0d: got %0d edges required %0d", i, lat, TAPS);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int               n;
    int               lat;
    logic [ACC_W-1:0] y;
    // History is all zero here, c0=1, c1=2.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'd10;
    tick();
    in_data = 16'd99;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    for (int c = 0; c < 10; c++) begin
      total += 3;
      if (out_valid !== 1'b1) $display("FAIL bp_out_valid cyc%0d: got %b required 1", c, out_valid); else passed++;
      if (out_data !== 34'd10) $display("FAIL bp_out_data cyc%0d: got %0d required 10", c, out_data); else passed++;
      if (read_en !== 1'b0) $display("FAIL bp_read_en cyc%0d: got %b required 0", c, read_en); else passed++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    total += 3;
    if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b required 0", out_valid); else passed++;
    if (read_en !== 1'b1) $display("FAIL bp_release_read_en: got %b required 1", read_en); else passed++;
    if (out_data !== 34'd10) $display("FAIL bp_hold_after_xfer: got %0d required 10", out_data); else passed++;
    // 99 must not have been popped: history becomes [0,10,0,0].
    push_sample(16'd0, 1'b0, 1'b0, 2'd0, 16'd0, lat, y);
    check_y("bp_no_pop", y, 34'd20);
  endtask

  task automatic test_signed();
    int               lat;
    logic [ACC_W-1:0] y;
    logic [ACC_W-1:0] exp_neg;
    set_coefs(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    for (int i = 0; i < 4; i++) push_sample(16'h8000, 1'b0, 1'b0, 2'd0, 16'd0, lat, y);
    check_y("signed_max_pos", y, 34'h1_0000_0000);
    set_coefs(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 4; i++) push_sample(16'd32767, 1'b0, 1'b0, 2'd0, 16'd0, lat, y);
    exp_neg = -34'sd131068;
    check_y("signed_neg", y, exp_neg);
  endtask

  task automatic test_coef_timing();
    int               lat;
    logic [ACC_W-1:0] y;
    set_coefs(16'd2, 16'd0, 16'd0, 16'd0);
    push_sample(16'd3, 1'b0, 1'b1, 2'd0, 16'd7, lat, y);
    check_y("coef_wr_in_mac_cur", y, 34'd6);
    push_sample(16'd5, 1'b0, 1'b0, 2'd0, 16'd0, lat, y);
    check_y("coef_wr_in_mac_next", y, 34'd10);
    push_sample(16'd4, 1'b1, 1'b0, 2'd0, 16'd7, lat, y);
    check_y("coef_wr_on_accept", y, 34'd28);
  endtask

  task automatic test_reset_mid_mac();
    int               lat;
    logic [ACC_W-1:0] y;
    in_valid = 1'b1; in_data = 16'd9;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total += 5;
    if (dbg_state !== 2'd0) $display("FAIL rst_mid_state: got %0d required 0", dbg_state); else passed++;
    if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b required 0", out_valid); else passed++;
    if (read_en !== 1'b1) $display("FAIL rst_mid_read_en: got %b required 1", read_en); else passed++;
    if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b required 0", busy); else passed++;
    if (out_data !== '0) $display("FAIL rst_mid_out_data: got %0d required 0", out_data); else passed++;
    // Only c1 set: result is the cleared previous history entry.
    write_coef(2'd1, 16'd1);
    push_sample(16'd5, 1'b0, 1'b0, 2'd0, 16'd0, lat, y);
    check_y("rst_mid_hist_coef_zero", y, 34'd0);
    write_coef(2'd1, 16'd0);
    write_coef(2'd0, 16'd1);
    push_sample(16'd5, 1'b0, 1'b0, 2'd0, 16'd0, lat, y);
    check_y("rst_mid_after", y, 34'd5);
  endtask

  initial begin
    #1;
    test_reset();
    test_impulse();
    test_backpressure();
    test_signed();
    test_coef_timing();
    test_reset_mid_mac();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fir_stream_mac.md
Name: fir_stream_mac

Overview:
Sequential FIR filter stage that sits directly downstream of the circular sample buffer. It pops one sample per output through the buffer's valid/read_en handshake and shifts it into a TAPS-deep history. It computes one signed multiply-accumulate per cycle and presents the result on a valid/ready output port. Coefficients come from a small write port and are held in registers.

Parameters:
DATA_W, 16, sample width (signed two's complement)
COEF_W, 16, coefficient width (signed)
TAPS, 8, filter length, >=2
ACC_W, DATA_W+COEF_W+$clog2(TAPS), accumulator and output width (derived, not overridden)

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  buffer holds a sample (buffer valid)
in_data  in  DATA_W  sample at buffer read pointer
read_en  out  1  pop request to buffer; a sample is taken on read_en & in_valid
coef_wen  in  1  coefficient write strobe
coef_addr  in  $clog2(TAPS)  coefficient index k
coef_data  in  COEF_W  coefficient value
out_valid  out  1  result available
out_data  out  ACC_W  y[n], signed
out_ready  in  1  downstream accepts; transfer on out_valid & out_ready
busy  out  1  high in MAC or OUT state

Behaviour:
- Function: y[n] = sum over k=0..TAPS-1 of c[k]*x[n-k]; x[n] is the newest sample. Arithmetic is signed, full precision, with no rounding or saturation. ACC_W bits cannot overflow.
- Reset (synchronous, rst=1 at an edge): state=IDLE; history, coefficients, accumulator, tap counter and out_data all 0; out_valid=0; busy=0. After reset, read_en=1. Reset has priority over every other event, including mid-MAC and mid-OUT.
- FSM states: IDLE, MAC, OUT.
- IDLE: read_en=1 (combinational from state). If in_valid=1, take the sample, shift the history (x[0]<=in_data, x[k]<=x[k-1]), clear acc, set k=0 and go to MAC. If in_valid=0, stay in IDLE with no state change.
- MAC: read_en=0. Each cycle, acc += c[k]*x[k] and k++. After the k=TAPS-1 cycle, load out_data from the final sum and go to OUT. Takes exactly TAPS cycles.
- OUT: out_valid=1, read_en=0. out_data stays stable until transfer. When out_ready=1, go to IDLE and clear out_valid. Otherwise hold indefinitely (backpressure).
- Latency: if the accept edge is at cycle c, out_valid rises at cycle c+TAPS+1. With out_ready held high, the next accept is possible at c+TAPS+2, giving a minimum period of TAPS+2 cycles per sample.
- Empty buffer: no sample is taken while in_valid=0. The block never issues a pop outside IDLE, so it cannot underrun the buffer.
- Coefficient writes: accepted only in IDLE, and take effect at that edge. If a write and a sample accept happen on the same IDLE edge, the MAC uses the new coefficient. Writes in MAC or OUT are dropped silently and leave coefficients unchanged.
- Wrap-around: the tap counter saturates its use at TAPS-1 and never indexes past TAPS-1. For non-power-of-2 TAPS, coef_addr >= TAPS is ignored.
- out_data keeps its last value after transfer and is only overwritten on MAC completion.

Decomposition:
- Shared package fir_pkg holds:
  - DATA_W, COEF_W and TAPS defaults
  - ACC_W derivation
  - FSM state encoding constants: IDLE=2'd0, MAC=2'd1, OUT=2'd2
- One natural sub-module, fir_mac_unit: signed multiplier plus accumulator register with clear/enable inputs, containing the datapath only.
- The FSM, history shift register, coefficient registers and tap mux stay in the top level.

Test Plan:
1. Reset, then idle with in_valid=0 for 5 cycles -> read_en=1, out_valid=0, out_data=0, busy=0 throughout; no state change.
2. TAPS=4, coefs {1,2,3,4}, push samples 1,0,0,0,0 with out_ready=1 -> outputs 1,2,3,4,0 in order. Each out_valid rises exactly 5 cycles after its accept edge.
3. Backpressure: hold out_ready=0 for 10 cycles while in_valid=1 -> out_valid stays 1, out_data is stable, read_en=0, and no sample is popped. Releasing out_ready gives one transfer, then IDLE.
4. Signed extremes: TAPS=4, all coefs -32768, push four samples -32768 -> 4th output = 4294967296 (2^32), with no overflow in the 34-bit result. Then set all coefs to -1 and push 32767 x4 -> -131068.
5. Coefficient write during MAC: write c[0]=7 while busy=1 -> ignored, and the next output uses the old c[0]. The same write issued in IDLE on the accept edge -> used immediately.
6. Assert rst mid-MAC (k=2) -> the next cycle shows IDLE, out_valid=0, read_en=1, with history and coefficients zeroed. After writing c[0]=1 and pushing 5 -> output 5.
